nios_security_ram_arbiter: RTL and testbench

- Shares the single-port on-chip RAM (32768 x 32, byte enables, 1-cycle read latency) between two Avalon-MM masters: CPU data port (m0) and a secure DMA/crypto engine (m1).
- Fair round-robin arbitration, one RAM access per clock, fully pipelined reads.
- Optional post-reset zeroization of the whole RAM before any master is granted.
- Sits between the interconnect master ports and the RAM's s1 slave.

---
 rtl/nios_security_ram_pkg.sv | 9 +
 rtl/nios_security_rr_arb2.sv | 18 +
 rtl/nios_security_ram_arbiter.sv | 92 +++++++++
 tb/tb_nios_security_ram_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/nios_security_ram_pkg.sv
// nios_security_ram_pkg: shared constants and types for the secure RAM arbiter.
package nios_security_ram_pkg;
  localparam int ADDR_W = 15;
  localparam int DATA_W = 32;
  localparam int BE_W = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;
  typedef enum logic {ZERO, RUN} state_e;
  typedef logic [0:0] mst_idx_t;
endpackage

// File: rtl/nios_security_rr_arb2.sv
// nios_security_rr_arb2: two-way round-robin grant; a tie goes to the master not granted last.
module nios_security_rr_arb2
  import nios_security_ram_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);
  mst_idx_t last_q, last_d;
  always_comb begin
    gnt_o[0] = en_i & req_i[0] & (~req_i[1] | (last_q == 1'b1));
    gnt_o[1] = en_i & req_i[1] & (~req_i[0] | (last_q == 1'b0));
    last_d = gnt_o[1] ? 1'b1 : gnt_o[0] ? 1'b0 : last_q;
  end
  always_ff @(posedge clk) last_q <= reset ? 1'b1 : last_d;
endmodule

// File: rtl/nios_security_ram_arbiter.sv
// nios_security_ram_arbiter: shares one single-port RAM between two Avalon-MM masters, round-robin.
// Define RAM_ZEROIZE_EN to wipe the whole RAM after reset before any master is granted.
module nios_security_ram_arbiter #(
  parameter int ADDR_W = nios_security_ram_pkg::ADDR_W,
  parameter int DATA_W = nios_security_ram_pkg::DATA_W,
  parameter int BE_W   = DATA_W / 8,
  parameter int DEPTH  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] ram_address,
  output logic [BE_W-1:0]   ram_byteenable,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_writedata,
  input  logic [DATA_W-1:0] ram_readdata,
  output logic              init_done
);
  import nios_security_ram_pkg::*;
  if (DEPTH != 2 ** ADDR_W) begin : g_depth_chk
    $error("DEPTH must equal 2**ADDR_W");
  end
  state_e state_q, state_d;
  logic [1:0] req, wr, gnt;
  logic run, zero_wr, rd_pend_q, rd_pend_d;
  mst_idx_t rd_owner_q, rd_owner_d;
  logic [ADDR_W-1:0] zaddr, addr_q;
  logic [BE_W-1:0] be_q;
  logic [DATA_W-1:0] wd_q;
  assign req = {m1_read | m1_write, m0_read | m0_write};
  assign wr = {m1_write, m0_write};
  // reset gates everything combinationally so nothing reaches the RAM while it is held
  assign run = (state_q == RUN) & ~reset;
  assign zero_wr = (state_q == ZERO) & ~reset;
`ifdef RAM_ZEROIZE_EN
  logic [ADDR_W-1:0] zaddr_q;
  assign zaddr = zaddr_q;
  always_ff @(posedge clk) zaddr_q <= reset ? '0 : zero_wr ? zaddr_q + 1'b1 : zaddr_q;
  always_comb state_d = (state_q == ZERO && zaddr_q == ADDR_W'(DEPTH - 1)) ? RUN : state_q;
  always_ff @(posedge clk) state_q <= reset ? ZERO : state_d;
`else
  assign zaddr = '0;
  always_comb state_d = RUN;
  always_ff @(posedge clk) state_q <= reset ? RUN : state_d;
`endif
  nios_security_rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .en_i  (run),
    .req_i (req),
    .gnt_o (gnt)
  );
  always_comb begin
    ram_chipselect = zero_wr | (|gnt);
    ram_write = zero_wr | (|(gnt & wr));
    ram_address = zero_wr ? zaddr : gnt[1] ? m1_address : gnt[0] ? m0_address : addr_q;
    ram_byteenable = zero_wr ? '1 : gnt[1] ? m1_byteenable : gnt[0] ? m0_byteenable : be_q;
    ram_writedata = zero_wr ? '0 : gnt[1] ? m1_writedata : gnt[0] ? m0_writedata : wd_q;
    rd_pend_d = |(gnt & ~wr);
    rd_owner_d = (|gnt) ? gnt[1] : rd_owner_q;
  end
  always_ff @(posedge clk) begin
    addr_q <= reset ? '0 : ram_address;
    be_q <= reset ? '0 : ram_byteenable;
    wd_q <= reset ? '0 : ram_writedata;
    rd_pend_q <= reset ? 1'b0 : rd_pend_d;
    rd_owner_q <= reset ? 1'b0 : rd_owner_d;
  end
  assign m0_waitrequest = req[0] & ~gnt[0];
  assign m1_waitrequest = req[1] & ~gnt[1];
  assign m0_readdatavalid = rd_pend_q & ~reset & (rd_owner_q == 1'b0);
  assign m1_readdatavalid = rd_pend_q & ~reset & (rd_owner_q == 1'b1);
  assign m0_readdata = ram_readdata;
  assign m1_readdata = ram_readdata;
  assign init_done = run;
endmodule

// File: tb/tb_nios_security_ram_arbiter.sv
// tb_nios_security_ram_arbiter: directed vectors against a behavioural 1-cycle RAM model.
module tb_nios_security_ram_arbiter;
  localparam int DEPTH = 32768;
`ifdef RAM_ZEROIZE_EN
  localparam bit ZE = 1'b1;
`else
  localparam bit ZE = 1'b0;
`endif
  logic clk, reset;
  logic [14:0] m0_address, m1_address, ram_address;
  logic [3:0] m0_byteenable, m1_byteenable, ram_byteenable;
  logic m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata, m0_readdata, m1_readdata, ram_writedata, ram_readdata;
  logic m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic ram_chipselect, ram_write, init_done;
  logic [31:0] mem [0:DEPTH-1];
  int vectors = 0, miscompares = 0;

  nios_security_ram_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .ram_address(ram_address), .ram_byteenable(ram_byteenable), .ram_chipselect(ram_chipselect),
    .ram_write(ram_write), .ram_writedata(ram_writedata), .ram_readdata(ram_readdata),
    .init_done(init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (ram_chipselect) begin
    if (ram_write)
      for (int b = 0; b < 4; b++)
        if (ram_byteenable[b]) mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
    ram_readdata <= mem[ram_address];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
  endtask

  task automatic drive(input bit m, input bit rd, input bit wr, input logic [14:0] a,
                       input logic [3:0] be, input logic [31:0] d);
    if (m) begin
      m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = d;
    end else begin
      m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = d;
    end
  endtask

  task automatic issue(input string tag, input bit m, input bit rd, input bit wr,
                       input logic [14:0] a, input logic [3:0] be, input logic [31:0] d);
    drive(m, rd, wr, a, be, d);
    @(negedge clk);
    chk({tag, "_wait"}, m ? m1_waitrequest : m0_waitrequest, 0);
    chk({tag, "_cs"}, ram_chipselect, 1);
    chk({tag, "_we"}, ram_write, wr);
    chk({tag, "_addr"}, ram_address, a);
    tick();
    idle();
  endtask

  task automatic rd_chk(input string tag, input bit m, input logic [14:0] a, input logic [31:0] exp);
    issue(tag, m, 1, 0, a, 4'hF, 0);
    @(negedge clk);
    chk({tag, "_rdv"}, m ? m1_readdatavalid : m0_readdatavalid, 1);
    chk({tag, "_other_rdv"}, m ? m0_readdatavalid : m1_readdatavalid, 0);
    chk({tag, "_data"}, m ? m1_readdata : m0_readdata, exp);
    tick();
  endtask

  task automatic wait_init();
    int n = 1;
    @(negedge clk);
    while (!init_done && n < DEPTH + 8) begin
      @(negedge clk);
      n++;
    end
    chk("init_cycles", n, ZE ? DEPTH + 1 : 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1;
    idle();
    m0_address = 0; m1_address = 0; m0_byteenable = 0; m1_byteenable = 0;
    m0_writedata = 0; m1_writedata = 0;
    repeat (2) tick();
    @(negedge clk);
    chk("rst_init_done", init_done, 0);
    chk("rst_cs", ram_chipselect, 0);
    chk("rst_we", ram_write, 0);
    chk("rst_rdv0", m0_readdatavalid, 0);
    chk("rst_rdv1", m1_readdatavalid, 0);
    chk("rst_wait0", m0_waitrequest, 0);
    tick();
    reset = 0;
    wait_init();
    tick();

    issue("t1_wr", 0, 0, 1, 15'h0010, 4'hF, 32'h1234_5678);
    @(negedge clk);
    chk("hold_addr", ram_address, 15'h0010);
    chk("hold_cs", ram_chipselect, 0);
    chk("hold_we", ram_write, 0);
    tick();
    rd_chk("t1_rd", 0, 15'h0010, 32'h1234_5678);

    issue("t2_pre0", 0, 0, 1, 15'h0020, 4'hF, 32'hA0A0_0020);
    issue("t2_pre1", 1, 0, 1, 15'h0030, 4'hF, 32'hB1B1_0030);
    m0_address = 15'h0020; m1_address = 15'h0030; m0_read = 1; m1_read = 1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k < 6) begin
        chk("t2_wait0", m0_waitrequest, 32'(k % 2));
        chk("t2_wait1", m1_waitrequest, 32'(1 - k % 2));
      end
      if (k > 0) begin
        chk("t2_rdv0", m0_readdatavalid, 32'((k - 1) % 2 == 0));
        chk("t2_rdv1", m1_readdatavalid, 32'((k - 1) % 2 == 1));
        chk("t2_data", ((k - 1) % 2 == 1) ? m1_readdata : m0_readdata,
            ((k - 1) % 2 == 1) ? 32'hB1B1_0030 : 32'hA0A0_0020);
      end
      tick();
      if (k == 5) idle();
    end

    issue("t3_pre", 0, 0, 1, 15'h0040, 4'hF, 32'h1122_3344);
    issue("t3_wr", 1, 0, 1, 15'h0040, 4'h3, 32'hAABB_CCDD);
    rd_chk("t3_rd", 1, 15'h0040, 32'h1122_CCDD);

    issue("t6_rw", 0, 1, 1, 15'h0050, 4'hF, 32'h0000_0005);
    @(negedge clk);
    chk("t6_no_rdv", m0_readdatavalid, 0);
    tick();
    rd_chk("t6_rd", 0, 15'h0050, 32'h0000_0005);

`ifdef RAM_ZEROIZE_EN
    issue("z_pre0", 0, 0, 1, 15'h0000, 4'hF, 32'hDEAD_BEEF);
    issue("z_pre1", 0, 0, 1, 15'h4000, 4'hF, 32'hDEAD_BEEF);
    issue("z_pre2", 1, 0, 1, 15'h7FFF, 4'hF, 32'hDEAD_BEEF);
`endif

    drive(0, 1, 0, 15'h0010, 4'hF, 0);
    @(negedge clk);
    chk("t4_acc", m0_waitrequest, 0);
    tick();
    reset = 1;
    idle();
    @(negedge clk);
    chk("t4_rdv_drop", m0_readdatavalid, 0);
    chk("t4_cs", ram_chipselect, 0);
    repeat (2) tick();
    reset = 0;
    wait_init();
    tick();
    m0_address = 15'h0010; m1_address = 15'h0020; m0_read = 1; m1_read = 1;
    @(negedge clk);
    chk("t4_tie_wait0", m0_waitrequest, 0);
    chk("t4_tie_wait1", m1_waitrequest, 1);
    tick();
    m0_read = 0;
    @(negedge clk);
    chk("t4_rdv0", m0_readdatavalid, 1);
    chk("t4_data0", m0_readdata, ZE ? 32'h0 : 32'h1234_5678);
    chk("t4_wait1", m1_waitrequest, 0);
    tick();
    m1_read = 0;
    @(negedge clk);
    chk("t4_rdv1", m1_readdatavalid, 1);
    chk("t4_data1", m1_readdata, ZE ? 32'h0 : 32'hA0A0_0020);
    tick();

`ifdef RAM_ZEROIZE_EN
    rd_chk("z_rd0", 0, 15'h0000, 32'h0);
    rd_chk("z_rd1", 1, 15'h4000, 32'h0);
    rd_chk("z_rd2", 0, 15'h7FFF, 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
